// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, freeze, flush and a
// saturating bubble counter.
module id_ex_stage #(
  parameter int SIZE         = 32,
  parameter int CONTROL_SIZE = 18,
  parameter int REG_DIR      = 5,
  parameter int CNT_SIZE     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [SIZE-1:0]         i_pc_plus4,
  input  logic [SIZE-1:0]         i_reg_a,
  input  logic [SIZE-1:0]         i_reg_b,
  input  logic [SIZE-1:0]         i_immediate,
  input  logic [REG_DIR-1:0]      i_dir_rs,
  input  logic [REG_DIR-1:0]      i_dir_rt,
  input  logic [REG_DIR-1:0]      i_dir_rd,
  input  logic [CONTROL_SIZE-1:0] i_control,
  output logic [SIZE-1:0]         o_pc_plus4,
  output logic [SIZE-1:0]         o_reg_a,
  output logic [SIZE-1:0]         o_reg_b,
  output logic [SIZE-1:0]         o_immediate,
  output logic [REG_DIR-1:0]      o_dir_rs,
  output logic [REG_DIR-1:0]      o_dir_rt,
  output logic [REG_DIR-1:0]      o_dir_rd,
  output logic [CONTROL_SIZE-1:0] o_control,
  output logic [REG_DIR-1:0]      o_write_dir,
  output logic                    o_valid,
  output logic                    o_hazard,
  output logic [CNT_SIZE-1:0]     o_bubble_count
);
  localparam int MEM_READ = 3;
  localparam int REG_DST  = 7;

  logic [SIZE-1:0]         r_pc_plus4, r_reg_a, r_reg_b, r_immediate;
  logic [REG_DIR-1:0]      r_dir_rs, r_dir_rt, r_dir_rd, r_write_dir;
  logic [CONTROL_SIZE-1:0] r_control;
  logic                    r_valid;
  logic [CNT_SIZE-1:0]     r_bubble_count;
  logic                    w_hazard;
  logic [REG_DIR-1:0]      w_write_dir;

  // $zero as a destination never creates a dependency
  assign w_hazard = r_valid & r_control[MEM_READ] & i_valid & ~i_flush &
                    (r_write_dir != '0) &
                    ((r_write_dir == i_dir_rs) | (r_write_dir == i_dir_rt));

  assign w_write_dir = i_control[REG_DST] ? i_dir_rd : i_dir_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_plus4     <= '0;
      r_reg_a        <= '0;
      r_reg_b        <= '0;
      r_immediate    <= '0;
      r_dir_rs       <= '0;
      r_dir_rt       <= '0;
      r_dir_rd       <= '0;
      r_write_dir    <= '0;
      r_control      <= '0;
      r_valid        <= 1'b0;
      r_bubble_count <= '0;
    end else if (i_stall) begin
      // freeze: everything holds, counter included
    end else if (i_flush || w_hazard) begin
      r_pc_plus4  <= '0;
      r_reg_a     <= '0;
      r_reg_b     <= '0;
      r_immediate <= '0;
      r_dir_rs    <= '0;
      r_dir_rt    <= '0;
      r_dir_rd    <= '0;
      r_write_dir <= '0;
      r_control   <= '0;
      r_valid     <= 1'b0;
      // only hazard bubbles are counted; flush has priority over hazard
      if (!i_flush && r_bubble_count != '1)
        r_bubble_count <= r_bubble_count + 1'b1;
    end else begin
      r_pc_plus4  <= i_pc_plus4;
      r_reg_a     <= i_reg_a;
      r_reg_b     <= i_reg_b;
      r_immediate <= i_immediate;
      r_dir_rs    <= i_dir_rs;
      r_dir_rt    <= i_dir_rt;
      r_dir_rd    <= i_dir_rd;
      r_write_dir <= w_write_dir;
      r_control   <= i_valid ? i_control : '0;
      r_valid     <= i_valid;
    end
  end

  assign o_pc_plus4     = r_pc_plus4;
  assign o_reg_a        = r_reg_a;
  assign o_reg_b        = r_reg_b;
  assign o_immediate    = r_immediate;
  assign o_dir_rs       = r_dir_rs;
  assign o_dir_rt       = r_dir_rt;
  assign o_dir_rd       = r_dir_rd;
  assign o_control      = r_control;
  assign o_write_dir    = r_write_dir;
  assign o_valid        = r_valid;
  assign o_hazard       = w_hazard;
  assign o_bubble_count = r_bubble_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 3-bit counter
// shares the stimulus so saturation is reachable in a few cycles.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, i_stall, i_flush, i_valid;
  logic [31:0] i_pc_plus4, i_reg_a, i_reg_b, i_immediate;
  logic [4:0]  i_dir_rs, i_dir_rt, i_dir_rd;
  logic [17:0] i_control;

  logic [31:0] o_pc_plus4, o_reg_a, o_reg_b, o_immediate;
  logic [4:0]  o_dir_rs, o_dir_rt, o_dir_rd, o_write_dir;
  logic [17:0] o_control;
  logic        o_valid, o_hazard;
  logic [15:0] o_bubble_count;

  logic [31:0] s_pc_plus4, s_reg_a, s_reg_b, s_immediate;
  logic [4:0]  s_dir_rs, s_dir_rt, s_dir_rd, s_write_dir;
  logic [17:0] s_control;
  logic        s_valid, s_hazard;
  logic [2:0]  s_bubble_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_pc_plus4(i_pc_plus4), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b), .i_immediate(i_immediate),
    .i_dir_rs(i_dir_rs), .i_dir_rt(i_dir_rt), .i_dir_rd(i_dir_rd), .i_control(i_control),
    .o_pc_plus4(o_pc_plus4), .o_reg_a(o_reg_a), .o_reg_b(o_reg_b), .o_immediate(o_immediate),
    .o_dir_rs(o_dir_rs), .o_dir_rt(o_dir_rt), .o_dir_rd(o_dir_rd), .o_control(o_control),
    .o_write_dir(o_write_dir), .o_valid(o_valid), .o_hazard(o_hazard),
    .o_bubble_count(o_bubble_count)
  );

  id_ex_stage #(.CNT_SIZE(3)) dut_s (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_pc_plus4(i_pc_plus4), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b), .i_immediate(i_immediate),
    .i_dir_rs(i_dir_rs), .i_dir_rt(i_dir_rt), .i_dir_rd(i_dir_rd), .i_control(i_control),
    .o_pc_plus4(s_pc_plus4), .o_reg_a(s_reg_a), .o_reg_b(s_reg_b), .o_immediate(s_immediate),
    .o_dir_rs(s_dir_rs), .o_dir_rt(s_dir_rt), .o_dir_rd(s_dir_rd), .o_control(s_control),
    .o_write_dir(s_write_dir), .o_valid(s_valid), .o_hazard(s_hazard),
    .o_bubble_count(s_bubble_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [17:0] ctl);
    i_valid = v; i_pc_plus4 = pc; i_reg_a = a; i_reg_b = b; i_immediate = imm;
    i_dir_rs = rs; i_dir_rt = rt; i_dir_rd = rd; i_control = ctl;
  endtask

  initial begin
    // reset held from time 0 with random inputs
    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    set_in(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
           5'($urandom), 18'($urandom));
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_control", 64'(o_control), 64'd0);
    chk("rst_pc", 64'(o_pc_plus4), 64'd0);
    chk("rst_write_dir", 64'(o_write_dir), 64'd0);
    chk("rst_hazard", 64'(o_hazard), 64'd0);
    chk("rst_count", 64'(o_bubble_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // pass-through, R-type style (REG_DST set)
    set_in(1'b1, 32'h8, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd1, 5'd3, 5'd9, 18'h00080);
    tick();
    chk("pt_pc", 64'(o_pc_plus4), 64'h8);
    chk("pt_reg_a", 64'(o_reg_a), 64'h11);
    chk("pt_reg_b", 64'(o_reg_b), 64'h22);
    chk("pt_imm", 64'(o_immediate), 64'hFFFF_FFFC);
    chk("pt_rs", 64'(o_dir_rs), 64'd1);
    chk("pt_rt", 64'(o_dir_rt), 64'd3);
    chk("pt_rd", 64'(o_dir_rd), 64'd9);
    chk("pt_control", 64'(o_control), 64'h80);
    chk("pt_write_dir", 64'(o_write_dir), 64'd9);
    chk("pt_valid", 64'(o_valid), 64'd1);
    chk("pt_hazard", 64'(o_hazard), 64'd0);

    // load-use via rs
    set_in(1'b1, 32'h10, 32'h33, 32'h44, 32'h4, 5'd2, 5'd5, 5'd9, 18'h00008);
    tick();
    chk("ld_write_dir", 64'(o_write_dir), 64'd5);
    chk("ld_control", 64'(o_control), 64'h8);
    set_in(1'b1, 32'h14, 32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 5'd7, 18'h00001);
    #1;
    chk("lu_hazard_rs", 64'(o_hazard), 64'd1);
    tick();
    chk("lu_bub_valid", 64'(o_valid), 64'd0);
    chk("lu_bub_control", 64'(o_control), 64'd0);
    chk("lu_bub_reg_a", 64'(o_reg_a), 64'd0);
    chk("lu_bub_write_dir", 64'(o_write_dir), 64'd0);
    chk("lu_count", 64'(o_bubble_count), 64'd1);
    chk("lu_hazard_clear", 64'(o_hazard), 64'd0);
    tick();
    chk("lu_dep_valid", 64'(o_valid), 64'd1);
    chk("lu_dep_rs", 64'(o_dir_rs), 64'd5);
    chk("lu_dep_reg_a", 64'(o_reg_a), 64'h55);
    chk("lu_dep_write_dir", 64'(o_write_dir), 64'd6);
    chk("lu_dep_count", 64'(o_bubble_count), 64'd1);

    // load-use via rt, then gated by i_valid=0
    set_in(1'b1, 32'h18, 32'h0, 32'h0, 32'h0, 5'd1, 5'd7, 5'd0, 18'h00008);
    tick();
    set_in(1'b1, 32'h1C, 32'h0, 32'h0, 32'h0, 5'd1, 5'd7, 5'd0, 18'h00001);
    #1;
    chk("lu_hazard_rt", 64'(o_hazard), 64'd1);
    i_valid = 1'b0;
    #1;
    chk("inv_no_hazard", 64'(o_hazard), 64'd0);
    tick();
    chk("inv_valid", 64'(o_valid), 64'd0);
    chk("inv_control", 64'(o_control), 64'd0);
    chk("inv_pc", 64'(o_pc_plus4), 64'h1C);
    chk("inv_count", 64'(o_bubble_count), 64'd1);

    // no false hazards: $zero destination, non-load producer
    set_in(1'b1, 32'h20, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 18'h00008);
    tick();
    set_in(1'b1, 32'h24, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0, 18'h00001);
    #1;
    chk("nf_zero_dest", 64'(o_hazard), 64'd0);
    set_in(1'b1, 32'h28, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 18'h00001);
    tick();
    set_in(1'b1, 32'h2C, 32'h0, 32'h0, 32'h0, 5'd5, 5'd3, 5'd0, 18'h00001);
    #1;
    chk("nf_non_load", 64'(o_hazard), 64'd0);

    // stall beats flush
    set_in(1'b1, 32'h40, 32'hAA, 32'hBB, 32'hCC, 5'd1, 5'd2, 5'd3, 18'h30000);
    tick();
    chk("sf_pre_pc", 64'(o_pc_plus4), 64'h40);
    i_stall = 1'b1; i_flush = 1'b1;
    set_in(1'b1, 32'h99, 32'h1, 32'h1, 32'h1, 5'd4, 5'd4, 5'd4, 18'h3FFFF);
    tick();
    tick();
    chk("sf_pc", 64'(o_pc_plus4), 64'h40);
    chk("sf_reg_a", 64'(o_reg_a), 64'hAA);
    chk("sf_control", 64'(o_control), 64'h30000);
    chk("sf_valid", 64'(o_valid), 64'd1);
    chk("sf_write_dir", 64'(o_write_dir), 64'd2);
    i_stall = 1'b0; i_flush = 1'b0;

    // flush while a hazard is pending
    set_in(1'b1, 32'h44, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 18'h00008);
    tick();
    set_in(1'b1, 32'h48, 32'h77, 32'h0, 32'h0, 5'd5, 5'd1, 5'd0, 18'h00001);
    #1;
    chk("fh_hazard_pre", 64'(o_hazard), 64'd1);
    i_flush = 1'b1;
    #1;
    chk("fh_hazard_masked", 64'(o_hazard), 64'd0);
    tick();
    chk("fh_valid", 64'(o_valid), 64'd0);
    chk("fh_control", 64'(o_control), 64'd0);
    chk("fh_reg_a", 64'(o_reg_a), 64'd0);
    chk("fh_count", 64'(o_bubble_count), 64'd1);
    i_flush = 1'b0;

    // stall holds a pending hazard, bubble lands on release
    set_in(1'b1, 32'h50, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 18'h00008);
    tick();
    set_in(1'b1, 32'h54, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 5'd0, 18'h00001);
    i_stall = 1'b1;
    tick();
    chk("sh_valid", 64'(o_valid), 64'd1);
    chk("sh_control", 64'(o_control), 64'h8);
    chk("sh_count", 64'(o_bubble_count), 64'd1);
    chk("sh_hazard", 64'(o_hazard), 64'd1);
    i_stall = 1'b0;
    tick();
    chk("sh_bub_valid", 64'(o_valid), 64'd0);
    chk("sh_bub_count", 64'(o_bubble_count), 64'd2);

    // back-to-back dependent loads alternate capture/bubble; 12 more bubbles
    set_in(1'b1, 32'h60, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0, 18'h00008);
    for (int i = 0; i < 12; i++) begin
      tick();
      tick();
    end
    chk("sat_count16", 64'(o_bubble_count), 64'd14);
    chk("sat_count3", 64'(s_bubble_count), 64'd7);
    tick();
    chk("b2b_valid", 64'(o_valid), 64'd1);
    chk("b2b_hazard", 64'(o_hazard), 64'd1);

    // asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_pc", 64'(o_pc_plus4), 64'd0);
    chk("arst_control", 64'(o_control), 64'd0);
    chk("arst_hazard", 64'(o_hazard), 64'd0);
    chk("arst_count", 64'(o_bubble_count), 64'd0);
    chk("arst_count3", 64'(s_bubble_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 32'h8, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd1, 5'd3, 5'd9, 18'h00080);
    tick();
    chk("post_rst_valid", 64'(o_valid), 64'd1);
    chk("post_rst_write_dir", 64'(o_write_dir), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between instruction decode and execute in the 5-stage MIPS core, with built-in load-use hazard detection. Captures the decoded operands, immediate, register addresses, PC+4 and the 18-bit control word each cycle. It inserts a one-cycle bubble when the instruction in EX is a load whose destination is a source of the instruction in ID. It also supports a global freeze (debug stall) and a flush (taken branch/jump), and counts inserted bubbles for performance monitoring.

## Interface
- SIZE, 32, datapath width
- CONTROL_SIZE, 18, control word width; bit 3 = MEM_READ, bit 7 = REG_DST
- REG_DIR, 5, register address width
- CNT_SIZE, 16, bubble counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_stall  in  1  global freeze; holds every register
- i_flush  in  1  squash the instruction entering EX
- i_valid  in  1  ID holds a real instruction
- i_pc_plus4  in  SIZE  PC+4 of the ID instruction
- i_reg_a, i_reg_b  in  SIZE  register file read data
- i_immediate  in  SIZE  sign/zero-extended immediate
- i_dir_rs, i_dir_rt, i_dir_rd  in  REG_DIR  register addresses
- i_control  in  CONTROL_SIZE  decoded control word
- o_pc_plus4, o_reg_a, o_reg_b, o_immediate  out  SIZE  registered copies
- o_dir_rs, o_dir_rt, o_dir_rd  out  REG_DIR  registered copies
- o_control  out  CONTROL_SIZE  registered control; all-zero for a bubble
- o_write_dir  out  REG_DIR  registered destination: rd if i_control[REG_DST] else rt
- o_valid  out  1  EX holds a real instruction
- o_hazard  out  1  combinational load-use detect; upstream holds IF and IF_ID while high
- o_bubble_count  out  CNT_SIZE  saturating count of hazard bubbles

## Operation
- Hazard:
  - o_hazard = o_valid & o_control[3] & i_valid & ~i_flush & (o_write_dir != 0) & (o_write_dir == i_dir_rs | o_write_dir == i_dir_rt).
  - rt is always compared. A false stall on an instruction that does not read rt is accepted.
- Per rising edge, in priority order:
  - rst: all outputs 0.
  - i_stall: hold all registers, including the counter.
  - i_flush: load a bubble. o_valid=0, o_control=0, all data/address outputs 0. Counter unchanged.
  - o_hazard: load a bubble, as above. o_bubble_count += 1, saturating at all-ones.
  - Otherwise: capture all inputs. o_valid=i_valid. o_control = i_valid ? i_control : 0. o_write_dir is selected from i_control[7].
- A bubble has o_valid=0, so o_hazard deasserts the following cycle. A load-use pair costs exactly one bubble.
- o_write_dir is computed at capture time, not recomputed from o_control.
- Two back-to-back loads where the second uses the first's destination: one bubble, then the second load enters EX and is itself checked against the next instruction.

## Timing
- Latency: 1 cycle from input to output for every registered field.
- o_hazard is combinational from the EX registers and the i_dir_rs/i_dir_rt/i_valid/i_flush inputs. Same-cycle response, no register.
- The upstream stages must hold IF and IF_ID in the cycle o_hazard is high. This block does not hold its own inputs.
- Reset is asynchronous: outputs clear immediately on rst assertion, mid-operation included. The first capture happens on the first rising edge after rst deasserts.
- i_stall and i_flush both high: the stall wins. Flush takes effect on the first unstalled edge only if it is still asserted.
- Hazard and stall both active: hold. The hazard is re-evaluated each cycle.

## Test plan
- Reset: drive random inputs, pulse rst between edges -> all outputs 0 immediately, o_hazard=0, o_bubble_count=0.
- Pass-through: i_valid=1, pc_plus4=0x8, reg_a=0x11, reg_b=0x22, imm=0xFFFFFFFC, rt=3, rd=9, control bit7=1 -> next edge outputs match, o_write_dir=9, o_valid=1.
- Load-use: cycle0 load (control bit3=1, bit7=0, rt=5). Cycle1 ID rs=5 -> o_hazard=1 in cycle1. After edge: o_valid=0, o_control=0, count=1, o_hazard=0. The next edge captures the dependent instruction.
- No false hazard: load with rt=0, next rs=0 -> o_hazard=0. Non-load (bit3=0) writing rt=5, next rs=5 -> o_hazard=0.
- Stall/flush priority: i_stall=1 with i_flush=1 for 2 cycles -> outputs unchanged. Flush while a hazard is pending -> bubble loaded, count unchanged, o_hazard=0.
- Saturation: preload via 65535 hazards (or a forced counter), one more hazard -> o_bubble_count stays 0xFFFF.
